// File: rtl/aes_round_sequencer.sv
// Sequences one AES-128 block encryption through a combinational aes_operations_unit,
// one unit operation per clock, holding the working state and key between operations.
module aes_round_sequencer #(
   parameter int unsigned DATA_W     = 128,
   parameter int unsigned NUM_ROUNDS = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [DATA_W-1:0] data_in_i,
   input  logic [DATA_W-1:0] key_in_i,
   input  logic [DATA_W-1:0] unit_result_i,
   output logic [DATA_W-1:0] unit_state_o,
   output logic [DATA_W-1:0] unit_key_o,
   output logic [DATA_W-1:0] unit_round_o,
   output logic [2:0]        unit_opcode_o,
   output logic              unit_en_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] data_out_o
);

   typedef enum logic [2:0] {
      StIdle, StArk0, StSub, StShift, StMix, StArk, StDone
   } fsm_e;

   localparam logic [2:0] OpSb  = 3'd0;
   localparam logic [2:0] OpSr  = 3'd1;
   localparam logic [2:0] OpMc  = 3'd2;
   localparam logic [2:0] OpArk = 3'd3;
   localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

   fsm_e              fsm_q, fsm_d;
   logic [3:0]        round_q, round_d;
   logic [DATA_W-1:0] state_q, state_d;
   logic [DATA_W-1:0] key_q, key_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic [2:0]        opcode_q, opcode_d;
   logic              en_q, en_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   always_comb begin
      fsm_d      = fsm_q;
      round_d    = round_q;
      state_d    = state_q;
      key_d      = key_q;
      data_out_d = data_out_q;
      case (fsm_q)
         StIdle: begin
            if (start_i) begin
               state_d = data_in_i;
               key_d   = key_in_i;
               round_d = 4'd0;
               fsm_d   = StArk0;
            end
         end
         StArk0: begin
            state_d = unit_result_i;
            round_d = 4'd1;
            fsm_d   = StSub;
         end
         StSub: begin
            state_d = unit_result_i;
            fsm_d   = StShift;
         end
         StShift: begin
            state_d = unit_result_i;
            // The final round has no MixColumns.
            fsm_d   = (round_q < LastRound) ? StMix : StArk;
         end
         StMix: begin
            state_d = unit_result_i;
            fsm_d   = StArk;
         end
         StArk: begin
            state_d = unit_result_i;
            if (round_q == LastRound) begin
               data_out_d = unit_result_i;
               fsm_d      = StDone;
            end else begin
               round_d = round_q + 4'd1;
               fsm_d   = StSub;
            end
         end
         StDone:  fsm_d = StIdle;
         default: fsm_d = StIdle;
      endcase
   end

   // Outputs are decoded from the next state so they are registered alongside it.
   always_comb begin
      opcode_d = OpSb;
      en_d     = 1'b0;
      busy_d   = (fsm_d != StIdle);
      done_d   = (fsm_d == StDone);
      case (fsm_d)
         StArk0:  begin opcode_d = OpArk; en_d = 1'b1; end
         StSub:   begin opcode_d = OpSb;  en_d = 1'b1; end
         StShift: begin opcode_d = OpSr;  en_d = 1'b1; end
         StMix:   begin opcode_d = OpMc;  en_d = 1'b1; end
         StArk:   begin opcode_d = OpArk; en_d = 1'b1; end
         default: begin opcode_d = OpSb;  en_d = 1'b0; end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fsm_q      <= StIdle;
         round_q    <= '0;
         state_q    <= '0;
         key_q      <= '0;
         data_out_q <= '0;
         opcode_q   <= OpSb;
         en_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         fsm_q      <= fsm_d;
         round_q    <= round_d;
         state_q    <= state_d;
         key_q      <= key_d;
         data_out_q <= data_out_d;
         opcode_q   <= opcode_d;
         en_q       <= en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign unit_state_o  = state_q;
   assign unit_key_o    = key_q;
   assign unit_round_o  = {{(DATA_W-4){1'b0}}, round_q};
   assign unit_opcode_o = opcode_q;
   assign unit_en_o     = en_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign data_out_o    = data_out_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench: a behavioural AES operations unit closes the loop around the sequencer,
// and results are compared against FIPS-197 vectors and the expected opcode/round trace.
module tb_aes_round_sequencer;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] data_in;
   logic [127:0] key_in;
   logic [127:0] unit_result;
   logic [127:0] unit_state;
   logic [127:0] unit_key;
   logic [127:0] unit_round;
   logic [2:0]   unit_opcode;
   logic         unit_en;
   logic         busy;
   logic         done;
   logic [127:0] data_out;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [127:0] FipsKey = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FipsPt  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FipsCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] ZeroCt  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   aes_round_sequencer dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start),
      .data_in_i     (data_in),
      .key_in_i      (key_in),
      .unit_result_i (unit_result),
      .unit_state_o  (unit_state),
      .unit_key_o    (unit_key),
      .unit_round_o  (unit_round),
      .unit_opcode_o (unit_opcode),
      .unit_en_o     (unit_en),
      .busy_o        (busy),
      .done_o        (done),
      .data_out_o    (data_out)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] r, inv;
      r = 8'h01;
      for (int i = 7; i >= 0; i--) begin
         r = gmul(r, r);
         if (i != 0) r = gmul(r, x);  // exponent 254 = 8'b1111_1110
      end
      inv = r;
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] round_key(input logic [127:0] key, input logic [3:0] r);
      logic [31:0] w0, w1, w2, w3, t;
      logic [7:0]  rcon;
      {w0, w1, w2, w3} = key;
      rcon = 8'h01;
      for (int i = 1; i <= int'(r); i++) begin
         t  = {w3[23:0], w3[31:24]};
         t  = {sbox(t[31:24]) ^ rcon, sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
         w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
         rcon = gmul(rcon, 8'h02);
      end
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [127:0] aes_unit(input logic [127:0] s, input logic [127:0] key,
                                             input logic [3:0] r, input logic [2:0] op);
      logic [127:0] res;
      logic [7:0]   a0, a1, a2, a3;
      res = s;
      case (op)
         3'd0: for (int i = 0; i < 16; i++) res[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
         3'd1: for (int c = 0; c < 4; c++)
                  for (int rw = 0; rw < 4; rw++)
                     res[127-8*(4*c+rw) -: 8] = s[127-8*(4*((c+rw)%4)+rw) -: 8];
         3'd2: for (int c = 0; c < 4; c++) begin
                  a0 = s[127-32*c -: 8];  a1 = s[119-32*c -: 8];
                  a2 = s[111-32*c -: 8];  a3 = s[103-32*c -: 8];
                  res[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                  res[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                  res[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                  res[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
               end
         3'd3: res = s ^ round_key(key, r);
         default: res = s;
      endcase
      return res;
   endfunction

   always_comb unit_result = aes_unit(unit_state, unit_key, unit_round[3:0], unit_opcode);

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [2:0] exp_op(input int k);
      if (k == 0) return 3'd3;
      if (k <= 36) return 3'((k - 1) % 4);
      if (k == 37) return 3'd0;
      if (k == 38) return 3'd1;
      return 3'd3;
   endfunction

   function automatic logic [3:0] exp_round(input int k);
      if (k == 0) return 4'd0;
      if (k <= 36) return 4'((k - 1) / 4 + 1);
      return 4'd10;
   endfunction

   // Steps on falling edges until done; traces opcode/round on every enabled cycle.
   task automatic wait_done(input bit hold, output int lat, output int en_cnt);
      lat = 0; en_cnt = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!hold) start = 1'b0;
         if (unit_en) begin
            check($sformatf("opcode[%0d]", en_cnt), 128'(unit_opcode), 128'(exp_op(en_cnt)));
            check($sformatf("round[%0d]", en_cnt), unit_round, 128'(exp_round(en_cnt)));
            en_cnt++;
         end
      end while (!done && lat < 200);
      check("done_seen", 128'(done), 128'd1);
   endtask

   task automatic run_job(input string tag, input logic [127:0] pt, input logic [127:0] key,
                          input logic [127:0] exp_ct);
      int lat, en_cnt;
      @(negedge clk);
      data_in = pt; key_in = key; start = 1'b1;
      wait_done(1'b0, lat, en_cnt);
      check({tag, "_latency"}, 128'(lat), 128'd41);
      check({tag, "_en_cycles"}, 128'(en_cnt), 128'd40);
      check({tag, "_data_out"}, data_out, exp_ct);
      check({tag, "_busy_in_done"}, 128'(busy), 128'd1);
      @(negedge clk);
      check({tag, "_done_pulse"}, 128'(done), 128'd0);
      check({tag, "_idle_busy"}, 128'(busy), 128'd0);
      check({tag, "_held"}, data_out, exp_ct);
   endtask

   initial begin
      int lat, en_cnt;
      rst = 1'b1; start = 1'b0; data_in = '0; key_in = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_done", 128'(done), 128'd0);
      check("rst_en", 128'(unit_en), 128'd0);
      check("rst_opcode", 128'(unit_opcode), 128'd0);
      check("rst_data_out", data_out, 128'd0);
      check("rst_state", unit_state, 128'd0);
      rst = 1'b0;

      run_job("fips", FipsPt, FipsKey, FipsCt);

      // Start held high: back-to-back jobs every 42 cycles.
      data_in = FipsPt; key_in = FipsKey; start = 1'b1;
      wait_done(1'b1, lat, en_cnt);
      check("hold_first_lat", 128'(lat), 128'd41);
      check("hold_first_ct", data_out, FipsCt);
      wait_done(1'b1, lat, en_cnt);
      check("hold_period", 128'(lat), 128'd42);
      check("hold_ct", data_out, FipsCt);
      start = 1'b0;
      @(negedge clk);
      check("hold_release_busy", 128'(busy), 128'd0);

      // Abort at op cycle 20 with a stray start.
      data_in = FipsPt; key_in = FipsKey; start = 1'b1;
      repeat (21) @(negedge clk) start = 1'b0;
      check("abort_pre_busy", 128'(busy), 128'd1);
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      check("abort_busy", 128'(busy), 128'd0);
      check("abort_done", 128'(done), 128'd0);
      check("abort_data_out", data_out, 128'd0);
      check("abort_en", 128'(unit_en), 128'd0);
      rst = 1'b0; start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_stays_idle", 128'(busy), 128'd0);
      run_job("after_abort", FipsPt, FipsKey, FipsCt);

      // Start during DONE is ignored; start in the next IDLE cycle is accepted.
      @(negedge clk);
      data_in = FipsPt; key_in = FipsKey; start = 1'b1;
      wait_done(1'b0, lat, en_cnt);
      data_in = '0; key_in = '0; start = 1'b1;
      @(negedge clk);
      check("done_start_busy", 128'(busy), 128'd0);
      check("done_start_held", data_out, FipsCt);
      wait_done(1'b0, lat, en_cnt);
      check("zero_lat", 128'(lat), 128'd41);
      check("zero_ct", data_out, ZeroCt);
      check("zero_key", unit_key, 128'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
